// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the VRAM1 access arbiter.
package vram_arb_pkg;

    localparam int unsigned AW_DEF    = 12;
    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned BURST_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VBURST,
        ST_CPU_WR,
        ST_CPU_RD,
        ST_CPU_RDCAP
    } state_e;

    // Beat counter width for a burst of the given length (clog2, at least 1).
    function automatic int unsigned bcnt_w(input int unsigned burst);
        return (burst < 32'd2) ? 32'd1 : 32'($clog2(burst));
    endfunction

endpackage

// File: rtl/vram_burst_cnt.sv
// Video burst address/beat generator: loads a base, steps with wrap, flags the final beat.
module vram_burst_cnt
    import vram_arb_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned BURST = BURST_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [AW-1:0] base_i,
    input  logic          adv_i,
    output logic [AW-1:0] next_addr_c_o,
    output logic          last_c_o
);

    localparam int unsigned CW = bcnt_w(BURST);

    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            addr_d = base_i;
            cnt_d  = '0;
        end else if (adv_i) begin
            addr_d = addr_q + AW'(1);
            cnt_d  = cnt_q + CW'(1);
        end
    end

    // Address wraps naturally at 2^AW.
    assign next_addr_c_o = addr_q + AW'(1);
    assign last_c_o      = (cnt_q == CW'(BURST - 1));

endmodule

// File: rtl/vram1_access_arb.sv
// VRAM1 single-port arbiter: video bursts take priority over CPU byte accesses.
// Optional sticky overflow flag on o_VOVF is built when VRAM1_ARB_OVF_EN is defined.
module vram1_access_arb
    import vram_arb_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned BURST = BURST_DEF
) (
    input  logic          i_MCLK,
    input  logic          i_RST,
    input  logic          i_CPU_REQ,
    input  logic          i_CPU_WE,
    input  logic [AW-1:0] i_CPU_ADDR,
    input  logic [DW-1:0] i_CPU_DIN,
    output logic          o_CPU_ACK,
    output logic [DW-1:0] o_CPU_DOUT,
    input  logic          i_VREQ,
    input  logic [AW-1:0] i_VADDR,
    output logic [DW-1:0] o_VDATA,
    output logic          o_VVALID,
    output logic          o_BUSY,
    output logic          o_VOVF,
    output logic [AW-1:0] o_RAM_ADDR,
    output logic [DW-1:0] o_RAM_DIN,
    output logic          o_RAM_WR_n,
    output logic          o_RAM_RD_n,
    input  logic [DW-1:0] i_RAM_DOUT
);

    state_e        state_q, state_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          wr_n_q, wr_n_d;
    logic          rd_n_q, rd_n_d;
    logic          ack_q, ack_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          vvalid_q, vvalid_d;
    logic          busy_q, busy_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;

    logic          vid_start_c;
    logic [AW-1:0] vid_base_c;
    logic [AW-1:0] burst_next_c;
    logic          burst_last_c;

    assign vid_start_c = (state_q == ST_IDLE) && (pend_q || i_VREQ);
    assign vid_base_c  = pend_q ? pend_addr_q : i_VADDR;

    vram_burst_cnt #(
        .AW    (AW),
        .BURST (BURST)
    ) u_burst_cnt (
        .clk_i         (i_MCLK),
        .rst_i         (i_RST),
        .load_i        (vid_start_c),
        .base_i        (vid_base_c),
        .adv_i         (state_q == ST_VBURST),
        .next_addr_c_o (burst_next_c),
        .last_c_o      (burst_last_c)
    );

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            state_q     <= ST_IDLE;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            wr_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            ack_q       <= 1'b0;
            dout_q      <= '0;
            vvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            wr_n_q      <= wr_n_d;
            rd_n_q      <= rd_n_d;
            ack_q       <= ack_d;
            dout_q      <= dout_d;
            vvalid_q    <= vvalid_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        wr_n_d      = 1'b1;
        rd_n_d      = 1'b1;
        ack_d       = 1'b0;
        dout_d      = dout_q;
        vvalid_d    = (state_q == ST_VBURST);
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;

        case (state_q)
            ST_IDLE: begin
                // The CPU request is ignored in the ACK cycle so a held REQ is not double-served.
                if (vid_start_c) begin
                    state_d    = ST_VBURST;
                    rd_n_d     = 1'b0;
                    ram_addr_d = vid_base_c;
                    pend_d     = 1'b0;
                end else if (i_CPU_REQ && !ack_q) begin
                    ram_addr_d = i_CPU_ADDR;
                    if (i_CPU_WE) begin
                        state_d   = ST_CPU_WR;
                        wr_n_d    = 1'b0;
                        ram_din_d = i_CPU_DIN;
                    end else begin
                        state_d = ST_CPU_RD;
                        rd_n_d  = 1'b0;
                    end
                end
            end
            ST_VBURST: begin
                if (burst_last_c) begin
                    state_d = ST_IDLE;
                end else begin
                    rd_n_d     = 1'b0;
                    ram_addr_d = burst_next_c;
                end
            end
            ST_CPU_WR: begin
                state_d = ST_IDLE;
                ack_d   = 1'b1;
            end
            ST_CPU_RD: begin
                state_d = ST_CPU_RDCAP;
            end
            ST_CPU_RDCAP: begin
                state_d = ST_IDLE;
                ack_d   = 1'b1;
                dout_d  = i_RAM_DOUT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // One-deep queue for a video request that lands while the port is busy.
        if (i_VREQ && (state_q != ST_IDLE) && !pend_q) begin
            pend_d      = 1'b1;
            pend_addr_d = i_VADDR;
        end

        busy_d = (state_d != ST_IDLE);
    end

`ifdef VRAM1_ARB_OVF_EN
    logic vovf_q, vovf_d;

    always_comb begin
        vovf_d = vovf_q | (i_VREQ & pend_q);
    end

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            vovf_q <= 1'b0;
        end else begin
            vovf_q <= vovf_d;
        end
    end

    assign o_VOVF = vovf_q;
`else
    assign o_VOVF = 1'b0;
`endif

    assign o_CPU_ACK  = ack_q;
    assign o_CPU_DOUT = dout_q;
    assign o_VDATA    = i_RAM_DOUT;
    assign o_VVALID   = vvalid_q;
    assign o_BUSY     = busy_q;
    assign o_RAM_ADDR = ram_addr_q;
    assign o_RAM_DIN  = ram_din_q;
    assign o_RAM_WR_n = wr_n_q;
    assign o_RAM_RD_n = rd_n_q;

endmodule

// File: tb/tb_vram1_access_arb.sv
// Self-checking bench for vram1_access_arb with a behavioural 4Kx8 SRAM and burst scoreboard.
module tb_vram1_access_arb;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 8;
    localparam int unsigned BURST = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_ack;
    logic [DW-1:0] cpu_dout;
    logic          vreq;
    logic [AW-1:0] vaddr;
    logic [DW-1:0] vdata;
    logic          vvalid, busy, vovf;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_wr_n, ram_rd_n;
    logic [DW-1:0] ram_dout;

    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;
    int            cyc = 0;
    logic [DW-1:0] vexp[$];

    vram1_access_arb #(.AW(AW), .DW(DW), .BURST(BURST)) dut (
        .i_MCLK     (clk),
        .i_RST      (rst),
        .i_CPU_REQ  (cpu_req),
        .i_CPU_WE   (cpu_we),
        .i_CPU_ADDR (cpu_addr),
        .i_CPU_DIN  (cpu_din),
        .o_CPU_ACK  (cpu_ack),
        .o_CPU_DOUT (cpu_dout),
        .i_VREQ     (vreq),
        .i_VADDR    (vaddr),
        .o_VDATA    (vdata),
        .o_VVALID   (vvalid),
        .o_BUSY     (busy),
        .o_VOVF     (vovf),
        .o_RAM_ADDR (ram_addr),
        .o_RAM_DIN  (ram_din),
        .o_RAM_WR_n (ram_wr_n),
        .o_RAM_RD_n (ram_rd_n),
        .i_RAM_DOUT (ram_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
    endfunction

    // SRAM model: unwritten locations read back the preload pattern.
    logic [DW-1:0] mem    [0:4095];
    bit            mem_wr [0:4095];
    always @(posedge clk) begin
        if (!ram_wr_n) begin
            mem[ram_addr]    <= ram_din;
            mem_wr[ram_addr] <= 1'b1;
        end
        if (!ram_rd_n) ram_dout <= mem_wr[ram_addr] ? mem[ram_addr] : pat(ram_addr);
    end

    logic [DW-1:0] ref_mem [0:4095];
    bit            ref_wr  [0:4095];

    function automatic logic [DW-1:0] exp_byte(input logic [AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : pat(a);
    endfunction

    task automatic push_burst(input logic [AW-1:0] base);
        for (int k = 0; k < int'(BURST); k++) vexp.push_back(exp_byte(12'(base + 12'(k))));
    endtask

    task automatic monitor_loop();
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checks++;
                if ((ram_wr_n | ram_rd_n) !== 1'b1) begin
                    errors++;
                    $display("FAIL strobe_overlap cyc=%0d wr_n=%b rd_n=%b required not both low", cyc, ram_wr_n, ram_rd_n);
                end
                if (vvalid === 1'b1) begin
                    checks++;
                    if (vexp.size() == 0) begin
                        errors++;
                        $display("FAIL vvalid_unexpected cyc=%0d data=%h required no beat", cyc, vdata);
                    end else begin
                        e = vexp.pop_front();
                        if (vdata !== e) begin
                            errors++;
                            $display("FAIL vdata cyc=%0d got=%h required=%h", cyc, vdata, e);
                        end
                    end
                end
            end
        end
    endtask

    task automatic cpu_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              output logic [DW-1:0] rd, output bit ok);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
        ok = 1'b0; rd = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) begin
                ok = 1'b1;
                rd = cpu_dout;
                break;
            end
        end
        cpu_req = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cpu_ack_timeout addr=%h got no ack required ack within 64 cycles", a);
        end
        if (ok && we) begin
            ref_mem[a] = d;
            ref_wr[a]  = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        vreq = 1'b0; vaddr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ram_addr, ram_din, cpu_dout, cpu_ack, vvalid, busy, vovf, ram_wr_n, ram_rd_n}
            !== {12'h000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_state addr=%h din=%h dout=%h ack=%b vv=%b busy=%b ovf=%b wr_n=%b rd_n=%b required zeros/strobes high",
                     ram_addr, ram_din, cpu_dout, cpu_ack, vvalid, busy, vovf, ram_wr_n, ram_rd_n);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, cpu_ack, vvalid, ram_wr_n, ram_rd_n} !== 5'b00011) begin
            errors++;
            $display("FAIL post_reset_idle busy=%b ack=%b vv=%b wr_n=%b rd_n=%b required 0 0 0 1 1",
                     busy, cpu_ack, vvalid, ram_wr_n, ram_rd_n);
        end
    endtask

    task automatic test_cpu_write_read();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_din = 8'h5A;
        @(negedge clk);
        checks++;
        if ({ram_wr_n, ram_rd_n, cpu_ack, busy} !== 4'b0101 || ram_addr !== 12'h123 || ram_din !== 8'h5A) begin
            errors++;
            $display("FAIL wr_cycle1 wr_n=%b rd_n=%b ack=%b busy=%b addr=%h din=%h required 0 1 0 1 123 5a",
                     ram_wr_n, ram_rd_n, cpu_ack, busy, ram_addr, ram_din);
        end
        @(negedge clk);
        checks++;
        if ({cpu_ack, ram_wr_n, busy} !== 3'b110) begin
            errors++;
            $display("FAIL wr_ack_cycle2 ack=%b wr_n=%b busy=%b required 1 1 0", cpu_ack, ram_wr_n, busy);
        end
        cpu_req = 1'b0;
        ref_mem[12'h123] = 8'h5A; ref_wr[12'h123] = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
        @(negedge clk);
        checks++;
        if ({ram_rd_n, ram_wr_n, cpu_ack} !== 3'b010 || ram_addr !== 12'h123) begin
            errors++;
            $display("FAIL rd_cycle1 rd_n=%b wr_n=%b ack=%b addr=%h required 0 1 0 123", ram_rd_n, ram_wr_n, cpu_ack, ram_addr);
        end
        @(negedge clk);
        checks++;
        if ({cpu_ack, busy, ram_rd_n} !== 3'b011) begin
            errors++;
            $display("FAIL rd_cycle2 ack=%b busy=%b rd_n=%b required 0 1 1", cpu_ack, busy, ram_rd_n);
        end
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b1 || cpu_dout !== exp_byte(12'h123)) begin
            errors++;
            $display("FAIL rd_ack_cycle3 ack=%b dout=%h required 1 %h", cpu_ack, cpu_dout, exp_byte(12'h123));
        end
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b0 || cpu_dout !== 8'h5A) begin
            errors++;
            $display("FAIL rd_dout_hold ack=%b dout=%h required 0 5a", cpu_ack, cpu_dout);
        end
        // REQ held through ACK: ignored in the ACK cycle, then starts a fresh write.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h124; cpu_din = 8'h77;
        repeat (3) @(negedge clk);
        checks++;
        if (ram_wr_n !== 1'b1 || cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL held_req_gap wr_n=%b ack=%b required 1 0", ram_wr_n, cpu_ack);
        end
        @(negedge clk);
        checks++;
        if (ram_wr_n !== 1'b0) begin
            errors++;
            $display("FAIL held_req_rewrite wr_n=%b required 0", ram_wr_n);
        end
        @(negedge clk);
        cpu_req = 1'b0;
        ref_mem[12'h124] = 8'h77; ref_wr[12'h124] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_video_burst();
        vreq = 1'b1; vaddr = 12'hFFC;
        push_burst(12'hFFC);
        for (int k = 1; k <= int'(BURST) + 2; k++) begin
            @(negedge clk);
            vreq = 1'b0;
            if (k <= int'(BURST)) begin
                checks++;
                if ({ram_rd_n, ram_wr_n, busy} !== 3'b011 || ram_addr !== 12'(12'hFFC + 12'(k - 1))) begin
                    errors++;
                    $display("FAIL vb_beat k=%0d rd_n=%b wr_n=%b busy=%b addr=%h required 0 1 1 %h",
                             k, ram_rd_n, ram_wr_n, busy, ram_addr, 12'(12'hFFC + 12'(k - 1)));
                end
            end else begin
                checks++;
                if ({ram_rd_n, busy} !== 2'b10) begin
                    errors++;
                    $display("FAIL vb_end k=%0d rd_n=%b busy=%b required 1 0", k, ram_rd_n, busy);
                end
            end
            checks++;
            if (vvalid !== ((k >= 2 && k <= int'(BURST) + 1) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL vb_vvalid k=%0d got=%b", k, vvalid);
            end
        end
        checks++;
        if (vexp.size() != 0) begin
            errors++;
            $display("FAIL vb_drain left=%0d required 0", vexp.size());
            vexp.delete();
        end
    endtask

    task automatic test_same_cycle();
        vreq = 1'b1; vaddr = 12'h010;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h200; cpu_din = 8'hA5;
        push_burst(12'h010);
        for (int c = 1; c <= int'(BURST) + 3; c++) begin
            @(negedge clk);
            vreq = 1'b0;
            checks++;
            if (ram_wr_n !== ((c == int'(BURST) + 2) ? 1'b0 : 1'b1) ||
                cpu_ack !== ((c == int'(BURST) + 3) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL same_cycle c=%0d wr_n=%b ack=%b", c, ram_wr_n, cpu_ack);
            end
        end
        cpu_req = 1'b0;
        ref_mem[12'h200] = 8'hA5; ref_wr[12'h200] = 1'b1;
        @(negedge clk);
        checks++;
        if (vexp.size() != 0) begin
            errors++;
            $display("FAIL same_cycle_drain left=%0d required 0", vexp.size());
            vexp.delete();
        end
    endtask

    task automatic test_overflow();
        bit exp_ovf;
`ifdef VRAM1_ARB_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        checks++;
        if (vovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_initial got=%b required 0", vovf);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
        @(negedge clk);
        vreq = 1'b1; vaddr = 12'h040;
        push_burst(12'h040);
        @(negedge clk);
        vaddr = 12'h080;
        @(negedge clk);
        vreq = 1'b0;
        checks++;
        if (cpu_ack !== 1'b1 || cpu_dout !== exp_byte(12'h123)) begin
            errors++;
            $display("FAIL ovf_cpu_ack ack=%b dout=%h required 1 %h", cpu_ack, cpu_dout, exp_byte(12'h123));
        end
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_rd_n !== 1'b0 || ram_addr !== 12'h040) begin
            errors++;
            $display("FAIL ovf_pending_start rd_n=%b addr=%h required 0 040", ram_rd_n, ram_addr);
        end
        repeat (BURST + 4) @(negedge clk);
        checks++;
        if (vexp.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain left=%0d busy=%b required 0 0", vexp.size(), busy);
            vexp.delete();
        end
        checks++;
        if (vovf !== exp_ovf) begin
            errors++;
            $display("FAIL ovf_flag got=%b required %b", vovf, exp_ovf);
        end
    endtask

    task automatic test_reset_mid_burst();
        vreq = 1'b1; vaddr = 12'h100;
        push_burst(12'h100);
        @(negedge clk);
        vreq = 1'b0;
        @(negedge clk);
        vreq = 1'b1; vaddr = 12'h300;
        @(negedge clk);
        vreq = 1'b0;
        mon_en = 1'b0;
        vexp.delete();
        rst = 1'b1;
        #1;
        checks++;
        if ({ram_rd_n, ram_wr_n, vvalid, busy, cpu_ack, vovf} !== 6'b110000 || ram_addr !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid_burst rd_n=%b wr_n=%b vv=%b busy=%b ack=%b ovf=%b addr=%h required 1 1 0 0 0 0 000",
                     ram_rd_n, ram_wr_n, vvalid, busy, cpu_ack, vovf, ram_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        for (int c = 0; c < int'(BURST) + 4; c++) begin
            @(negedge clk);
            checks++;
            if ({ram_rd_n, vvalid, busy} !== 3'b100) begin
                errors++;
                $display("FAIL rst_pending_cleared c=%0d rd_n=%b vv=%b busy=%b required 1 0 0", c, ram_rd_n, vvalid, busy);
            end
        end
    endtask

    task automatic test_random_traffic();
        int end_cyc;
        end_cyc = cyc + 10000;
        fork
            begin : cpu_thr
                bit            we, ok;
                logic [AW-1:0] a;
                logic [DW-1:0] d, rd, exp_rd;
                while (cyc < end_cyc) begin
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    we     = 1'($urandom_range(0, 1));
                    a      = 12'($urandom_range(12'h800, 12'hFFF));
                    d      = 8'($urandom);
                    exp_rd = exp_byte(a);
                    cpu_access(we, a, d, rd, ok);
                    if (ok && !we) begin
                        checks++;
                        if (rd !== exp_rd) begin
                            errors++;
                            $display("FAIL rand_cpu_read addr=%h got=%h required=%h", a, rd, exp_rd);
                        end
                    end
                end
            end
            begin : vid_thr
                int waited;
                while (cyc < end_cyc) begin
                    repeat ($urandom_range(1, 12)) @(negedge clk);
                    vaddr = 12'($urandom_range(0, 12'h7F8));
                    vreq  = 1'b1;
                    push_burst(vaddr);
                    @(negedge clk);
                    vreq   = 1'b0;
                    waited = 0;
                    while (vexp.size() != 0 && waited < 200) begin
                        @(negedge clk);
                        waited++;
                    end
                    checks++;
                    if (vexp.size() != 0) begin
                        errors++;
                        $display("FAIL rand_burst_timeout left=%0d required 0", vexp.size());
                        vexp.delete();
                    end
                end
            end
        join
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog sim time expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor_loop();
        join_none
        test_reset();
        mon_en = 1'b1;
        test_cpu_write_read();
        test_video_burst();
        test_same_cycle();
        test_overflow();
        test_reset_mid_burst();
        test_random_traffic();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
